// File: rtl/factorial_sequencer.sv
// Computes n! by driving an external 64x64 multiplier with ascending indices 2..n.
// Stops early with overflow once a partial product no longer fits in 64 bits.
module factorial_sequencer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  n,
  output logic         op_done,
  output logic         busy,
  output logic         overflow,
  output logic [127:0] result,
  output logic         mul_op_start,
  output logic         mul_op_clear,
  output logic [63:0]  mul_multiplier,
  output logic [63:0]  mul_multiplicand,
  input  logic         mul_op_done,
  input  logic [127:0] mul_result
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_STEP  = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [63:0]  r_n_q;
  logic [63:0]  w_n_q_nxt;
  logic [63:0]  r_i;
  logic [63:0]  w_i_nxt;
  logic [127:0] r_acc;
  logic [127:0] w_acc_nxt;
  logic         r_ovf;
  logic         w_ovf_nxt;
  logic         w_accept;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_n_q   <= 64'd0;
      r_i     <= 64'd0;
      r_acc   <= 128'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n_q   <= w_n_q_nxt;
      r_i     <= w_i_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_n_q_nxt   = r_n_q;
    w_i_nxt     = r_i;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_accept    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (op_start && !op_clear) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (op_clear) begin
          w_state_nxt = ST_ABORT;
        end else if (mul_op_done) begin
          w_acc_nxt   = mul_result;
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_STEP: begin
        // The multiplicand is only 64 bits, so a wide partial product ends the run.
        if (op_clear) begin
          w_state_nxt = ST_ABORT;
        end else if (r_i == r_n_q) begin
          w_state_nxt = ST_DONE;
        end else if (r_acc[127:64] != 64'd0) begin
          w_ovf_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_i_nxt     = r_i + 64'd1;
          w_state_nxt = ST_MUL;
        end
      end
      ST_ABORT: begin
        w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (op_clear) begin
          w_state_nxt = ST_IDLE;
        end else if (op_start) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_n_q_nxt   = n;
      w_i_nxt     = 64'd2;
      w_acc_nxt   = 128'd1;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = (n < 64'd2) ? ST_DONE : ST_MUL;
    end else begin
      w_n_q_nxt = w_n_q_nxt;
    end
  end

  // Output decode from the registered state; result is masked outside DONE.
  always_comb begin
    op_done          = 1'b0;
    busy             = 1'b0;
    overflow         = 1'b0;
    result           = 128'd0;
    mul_op_start     = 1'b0;
    mul_op_clear     = 1'b0;
    mul_multiplier   = 64'd0;
    mul_multiplicand = 64'd0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_MUL: begin
        busy             = 1'b1;
        mul_op_start     = 1'b1;
        mul_multiplier   = r_i;
        mul_multiplicand = r_acc[63:0];
      end
      ST_STEP: begin
        busy         = 1'b1;
        mul_op_clear = 1'b1;
      end
      ST_ABORT: begin
        busy         = 1'b1;
        mul_op_clear = 1'b1;
      end
      ST_DONE: begin
        op_done  = 1'b1;
        result   = r_acc;
        overflow = r_ovf;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_factorial_sequencer.sv
// Self-checking bench: behavioural factorial model plus a variable-latency multiplier.
module tb_factorial_sequencer;

  logic         clk;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  n;
  logic         op_done;
  logic         busy;
  logic         overflow;
  logic [127:0] result;
  logic         mul_op_start;
  logic         mul_op_clear;
  logic [63:0]  mul_multiplier;
  logic [63:0]  mul_multiplicand;
  logic         mul_op_done;
  logic [127:0] mul_result;

  int vectors = 0;
  int miscompares = 0;
  int mul_starts = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_result = 128'd0;
  logic         exp_ovf = 1'b0;
  logic         exp_valid = 1'b0;

  localparam logic [127:0] F21 = 128'd51090942171709440000;

  factorial_sequencer dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear), .n(n),
    .op_done(op_done), .busy(busy), .overflow(overflow), .result(result),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_op_done(mul_op_done), .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Multiplier stand-in with random 1..4 cycle latency; done held until cleared.
  logic        m_run;
  int          m_cnt;
  logic [63:0] m_a, m_b;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_op_done <= 1'b0; mul_result <= 128'd0; m_run <= 1'b0; m_cnt <= 0;
      m_a <= 64'd0; m_b <= 64'd0;
    end else if (mul_op_clear) begin
      mul_op_done <= 1'b0; mul_result <= 128'd0; m_run <= 1'b0;
    end else if (m_run) begin
      if (m_cnt <= 1) begin
        mul_op_done <= 1'b1;
        mul_result  <= {64'd0, m_a} * {64'd0, m_b};
        m_run       <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mul_op_start && !mul_op_done) begin
      m_run <= 1'b1;
      m_cnt <= $urandom_range(1, 4);
      m_a   <= mul_multiplier;
      m_b   <= mul_multiplicand;
    end
  end

  // Reference: multiply 2,3,... until i==n or the product exceeds 64 bits.
  task automatic build_model(input logic [63:0] nv);
    logic [127:0] acc;
    logic [63:0]  i;
    exp_q.delete();
    acc = 128'd1;
    exp_ovf = 1'b0;
    if (nv >= 64'd2) begin
      i = 64'd2;
      forever begin
        exp_q.push_back({i, acc[63:0]});
        acc = acc * {64'd0, i};
        if (i == nv) break;
        if (acc > 128'hFFFF_FFFF_FFFF_FFFF) begin
          exp_ovf = 1'b1;
          break;
        end
        i = i + 64'd1;
      end
    end
    exp_result = acc;
  endtask

  // Per-cycle compare process.
  logic prev_start = 1'b0;
  initial begin
    logic [127:0] item;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        check("reset_outputs", {op_done, busy, overflow, mul_op_start, mul_op_clear}, 128'd0);
        check("reset_data", result | {mul_multiplier, mul_multiplicand}, 128'd0);
        prev_start = 1'b0;
      end else begin
        if (op_done) begin
          check("done_expected", {127'd0, exp_valid}, 128'd1);
          check("result", result, exp_result);
          check("overflow", {127'd0, overflow}, {127'd0, exp_ovf});
        end else begin
          check("result_masked", result, 128'd0);
        end
        check("done_busy_excl", {127'd0, op_done & busy}, 128'd0);
        check("start_clear_excl", {127'd0, mul_op_start & mul_op_clear}, 128'd0);
        if (mul_op_start && !prev_start) begin
          mul_starts++;
          if (exp_q.size() == 0) begin
            check("mul_unexpected_start", 128'd1, 128'd0);
          end else begin
            item = exp_q.pop_front();
            check("mul_multiplier", {64'd0, mul_multiplier}, {64'd0, item[127:64]});
            check("mul_multiplicand", {64'd0, mul_multiplicand}, {64'd0, item[63:0]});
          end
        end
        prev_start = mul_op_start;
      end
    end
  end

  task automatic do_start(input logic [63:0] nv);
    build_model(nv);
    @(negedge clk);
    n = nv; op_start = 1'b1; exp_valid = 1'b1;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #2;
      if (op_done) begin seen = 1'b1; break; end
    end
    check("done_timeout", {127'd0, seen}, 128'd1);
    check("handshakes_consumed", exp_q.size(), 128'd0);
  endtask

  task automatic run(input logic [63:0] nv, input bit poke);
    int base;
    base = mul_starts;
    do_start(nv);
    @(posedge clk); #2;
    if (nv < 64'd2) begin
      check("short_done", {127'd0, op_done}, 128'd1);
      check("short_result", result, 128'd1);
    end
    @(negedge clk); op_start = 1'b0;
    if (poke) begin
      @(negedge clk); @(negedge clk);
      check("poke_busy", {127'd0, busy}, 128'd1);
      n = 64'd9; op_start = 1'b1;
      @(negedge clk); op_start = 1'b0;
    end
    wait_done();
    if (nv < 64'd2) check("short_no_mul", mul_starts - base, 128'd0);
  endtask

  task automatic do_clear();
    @(negedge clk); op_clear = 1'b1;
    @(posedge clk); #2;
    check("clear_idle", {126'd0, op_done, busy}, 128'd0);
    @(negedge clk); op_clear = 1'b0; exp_valid = 1'b0;
  endtask

  initial begin
    bit got3;
    logic [63:0] nv;
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; n = 64'd0;
    #2;
    check("por_outputs", {op_done, busy, overflow, mul_op_start, mul_op_clear}, 128'd0);
    check("por_result", result, 128'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Model pins against hand-computed factorials.
    build_model(64'd5);  check("model_5", exp_result, 128'd120);
    build_model(64'd21); check("model_21", exp_result, F21);
    build_model(64'd22); check("model_22", {127'd0, exp_ovf}, 128'd1);

    run(64'd5, 1'b0);
    check("n5_result", result, 128'd120);
    check("n5_ovf", {127'd0, overflow}, 128'd0);
    do_clear();
    run(64'd0, 1'b0);
    run(64'd1, 1'b0);
    run(64'd21, 1'b0);
    check("n21_result", result, F21);
    check("n21_ovf", {127'd0, overflow}, 128'd0);
    run(64'd22, 1'b0);
    check("n22_result", result, F21);
    check("n22_ovf", {127'd0, overflow}, 128'd1);
    do_clear();

    // Abort during the third multiply of n=10.
    begin
      int base;
      base = mul_starts;
      do_start(64'd10);
      @(negedge clk); op_start = 1'b0;
      got3 = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #2;
        if (mul_starts == base + 3) begin got3 = 1'b1; break; end
      end
      check("abort_reach_mul3", {127'd0, got3}, 128'd1);
      @(negedge clk); op_clear = 1'b1;
      @(posedge clk); #2;
      check("abort_state", {125'd0, busy, mul_op_clear, mul_op_start}, 128'd6);
      @(negedge clk); op_clear = 1'b0;
      @(posedge clk); #2;
      check("abort_idle", {125'd0, busy, mul_op_clear, op_done}, 128'd0);
      exp_q.delete(); exp_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 check("abort_no_done", {127'd0, op_done}, 128'd0);
    end

    run(64'd6, 1'b1);
    check("n6_result", result, 128'd720);
    run(64'd3, 1'b0);
    check("n3_result", result, 128'd6);

    // Asynchronous reset in the middle of a run.
    do_start(64'd12);
    @(negedge clk); op_start = 1'b0;
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrun_reset", {op_done, busy, overflow, mul_op_start, mul_op_clear}, 128'd0);
    check("midrun_reset_result", result, 128'd0);
    exp_q.delete(); exp_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("post_reset_idle", {126'd0, busy, op_done}, 128'd0);

    // Randomized runs, sometimes restarting straight from DONE.
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) nv = {$urandom, $urandom};
      else nv = 64'($urandom_range(0, 24));
      if ($urandom_range(0, 2) == 0) do_clear();
      run(nv, ($urandom_range(0, 3) == 0) && (nv > 64'd3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
